// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the
// VGA fetch port (priority) and the CPU bus port.
module vram_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            disp_req,
  input  logic [AW-1:0]   disp_addr,
  output logic [DW-1:0]   disp_rdata,
  output logic            disp_rvalid,
  output logic            disp_overrun,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [DW/8-1:0] cpu_be,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_ack,
  output logic [DW-1:0]   cpu_rdata,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic          pend_vld;
  logic [AW-1:0] pend_addr;
  logic [CW-1:0] wait_cnt;
  logic          cpu_busy;
  logic          s1_disp;
  logic          s1_cpu;

  logic          disp_cand;
  logic          cpu_cand;
  logic          at_max;
  logic          cpu_win;
  logic          disp_win;
  logic [AW-1:0] disp_sel;

  logic          pend_vld_n;
  logic [AW-1:0] pend_addr_n;
  logic          ovr_set;
  logic [CW-1:0] wait_cnt_n;

  // Winner selection: display first unless the CPU has starved.
  always_comb begin
    disp_cand = pend_vld | disp_req;
    cpu_cand  = cpu_req & ~cpu_busy;
    at_max    = (wait_cnt == CW'(MAX_WAIT));
    cpu_win   = cpu_cand & (~disp_cand | at_max);
    disp_win  = disp_cand & ~cpu_win;
    disp_sel  = pend_vld ? pend_addr : disp_addr;
  end

  // Pending slot, overrun detect and starvation counter update.
  always_comb begin
    pend_vld_n  = pend_vld;
    pend_addr_n = pend_addr;
    ovr_set     = 1'b0;
    wait_cnt_n  = wait_cnt;
    if (pend_vld) begin
      if (disp_win) begin
        pend_vld_n = disp_req;
        if (disp_req) pend_addr_n = disp_addr;
      end else if (disp_req) begin
        ovr_set = 1'b1;
      end
    end else if (disp_req && !disp_win) begin
      pend_vld_n  = 1'b1;
      pend_addr_n = disp_addr;
    end
    if (cpu_win || !cpu_req)
      wait_cnt_n = '0;
    else if (cpu_cand && !at_max)
      wait_cnt_n = wait_cnt + CW'(1);
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld     <= 1'b0;
      pend_addr    <= '0;
      wait_cnt     <= '0;
      disp_overrun <= 1'b0;
    end else begin
      pend_vld     <= pend_vld_n;
      pend_addr    <= pend_addr_n;
      wait_cnt     <= wait_cnt_n;
      disp_overrun <= disp_overrun | ovr_set;
    end
  end

  // Register the winning command onto the RAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= cpu_win | disp_win;
      ram_we <= (cpu_win && cpu_we) ? cpu_be : BW'(0);
      if (cpu_win) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end else if (disp_win) begin
        ram_addr  <= disp_sel;
      end
    end
  end

  // Track issued accesses to the read-data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_disp     <= 1'b0;
      s1_cpu      <= 1'b0;
      disp_rvalid <= 1'b0;
      cpu_ack     <= 1'b0;
    end else begin
      s1_disp     <= disp_win;
      s1_cpu      <= cpu_win;
      disp_rvalid <= s1_disp;
      cpu_ack     <= s1_cpu;
    end
  end

  // CPU stays busy from grant through its ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cpu_busy <= 1'b0;
    else if (cpu_win)
      cpu_busy <= 1'b1;
    else if (cpu_ack)
      cpu_busy <= 1'b0;
  end

  assign disp_rdata = disp_rvalid ? ram_rdata : '0;
  assign cpu_rdata  = cpu_ack ? ram_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random + directed stimulus against a
// queue-based reference model of the VRAM arbiter.
module tb_vram_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          disp_overrun;
  logic          cpu_req;
  logic          cpu_we;
  logic [BW-1:0] cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          ram_en;
  logic [BW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .disp_overrun(disp_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // single-port RAM, one cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < BW; b++)
        if (ram_we[b])
          mem[ram_addr][b*8+:8] <= ram_wdata[b*8+:8];
      ram_rdata <= mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: display backlog queue, wait and busy counters
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [AW-1:0] dq[$];
  int            wcnt;
  int            busy;
  bit            ovf;
  int unsigned   cyc = 0;
  bit            e_rv  [4];
  bit            e_ack [4];
  bit            e_ard [4];
  bit            e_en  [4];
  logic [DW-1:0] e_rd  [4];
  logic [DW-1:0] e_ad  [4];
  logic [BW-1:0] e_we  [4];
  bit            m_cd, m_cc, m_cw, m_dw;
  logic [AW-1:0] m_a;
  int            m_s1, m_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq.delete();
      wcnt = 0;
      busy = 0;
      ovf  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        e_rv[i] = 0; e_ack[i] = 0; e_ard[i] = 0;
        e_en[i] = 0; e_we[i] = '0;
      end
      shadow = mem;
    end else begin
      m_s1 = int'((cyc + 1) % 4);
      m_s2 = int'((cyc + 2) % 4);
      e_rv[m_s2]  = 0;
      e_ack[m_s2] = 0;
      m_cd = (dq.size() > 0) || disp_req;
      m_cc = cpu_req && (busy == 0);
      m_cw = m_cc && (!m_cd || wcnt == MW);
      m_dw = m_cd && !m_cw;
      e_en[m_s1] = m_cw || m_dw;
      e_we[m_s1] = '0;
      if (m_cw) begin
        e_ack[m_s2] = 1;
        e_ard[m_s2] = !cpu_we;
        if (cpu_we) begin
          e_we[m_s1] = cpu_be;
          for (int b = 0; b < BW; b++)
            if (cpu_be[b])
              shadow[cpu_addr][b*8+:8] = cpu_wdata[b*8+:8];
        end else begin
          e_ad[m_s2] = shadow[cpu_addr];
        end
      end
      if (m_dw) begin
        if (dq.size() > 0) begin
          m_a = dq.pop_front();
          if (disp_req) dq.push_back(disp_addr);
        end else begin
          m_a = disp_addr;
        end
        e_rv[m_s2] = 1;
        e_rd[m_s2] = shadow[m_a];
      end else if (disp_req) begin
        if (dq.size() > 0) ovf = 1'b1;
        else dq.push_back(disp_addr);
      end
      if (m_cw || !cpu_req) wcnt = 0;
      else if (m_cc && wcnt < MW) wcnt++;
      if (m_cw) busy = 2;
      else if (busy > 0) busy--;
      cyc++;
    end
  end

  int rv_cnt  = 0;
  int ack_cnt = 0;
  int cs;

  // compare every live cycle against the model
  always @(negedge clk) begin
    if (rst_n) begin
      cs = int'(cyc % 4);
      chk("disp_rvalid", 32'(disp_rvalid), 32'(e_rv[cs]));
      if (e_rv[cs])
        chk("disp_rdata", disp_rdata, e_rd[cs]);
      chk("cpu_ack", 32'(cpu_ack), 32'(e_ack[cs]));
      if (e_ack[cs] && e_ard[cs])
        chk("cpu_rdata", cpu_rdata, e_ad[cs]);
      chk("ram_en", 32'(ram_en), 32'(e_en[cs]));
      chk("ram_we", 32'(ram_we), 32'(e_we[cs]));
      chk("disp_overrun", 32'(disp_overrun), 32'(ovf));
      if (disp_rvalid) rv_cnt++;
      if (cpu_ack) ack_cnt++;
    end
  end

  task automatic rst_outputs();
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_rvalid", 32'(disp_rvalid), 32'h0);
    chk("rst_rdata", disp_rdata, 32'h0);
    chk("rst_ack", 32'(cpu_ack), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_overrun", 32'(disp_overrun), 32'h0);
  endtask

  task automatic reset_pulse();
    int rv0, ak0;
    @(negedge clk);
    rst_n    = 1'b0;
    disp_req = 1'b0;
    cpu_req  = 1'b0;
    #1;
    rst_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    rv0 = rv_cnt;
    ak0 = ack_cnt;
    repeat (5) @(negedge clk);
    chk("post_rst_rvalid", 32'(rv_cnt - rv0), 32'h0);
    chk("post_rst_ack", 32'(ack_cnt - ak0), 32'h0);
  endtask

  task automatic cpu_op(input bit we,
                        input logic [BW-1:0] be,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd,
                        output int lat);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_be    = be;
    cpu_addr  = a;
    cpu_wdata = wd;
    rd  = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < 50);
    if (!cpu_ack) chk("cpu_op_timeout", 32'(lat), 32'h0);
    else rd = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  task automatic disp_stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      disp_req  = 1'b1;
      disp_addr = AW'(base + i);
    end
    @(negedge clk);
    disp_req = 1'b0;
  endtask

  logic [DW-1:0] rd;
  int            lat, lat2;
  int            rv0;
  int            hold;

  initial begin
    rst_n     = 1'b0;
    disp_req  = 1'b0;
    disp_addr = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_be    = '0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_rvalid", 32'(rv_cnt), 32'h0);
    chk("idle_ack", 32'(ack_cnt), 32'h0);

    // CPU write / read / partial write
    cpu_op(1, 4'hF, 14'h0010, 32'hDEADBEEF, rd, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    cpu_op(0, 4'h0, 14'h0010, 32'h0, rd, lat);
    chk("rd_full", rd, 32'hDEADBEEF);
    cpu_op(1, 4'h1, 14'h0010, 32'h00000055, rd, lat);
    cpu_op(0, 4'h0, 14'h0010, 32'h0, rd, lat);
    chk("rd_byte", rd, 32'hDEADBE55);

    // display streaming over distinct data
    for (int i = 0; i < 8; i++)
      cpu_op(1, 4'hF, AW'(i), 32'hA0B0C000 + 32'(i), rd, lat);
    rv0 = rv_cnt;
    disp_stream(8, 0);
    repeat (4) @(negedge clk);
    chk("stream_count", 32'(rv_cnt - rv0), 32'd8);
    chk("stream_ovr", 32'(disp_overrun), 32'h0);

    // starvation then forced grant with pending full
    rv0 = rv_cnt;
    fork
      disp_stream(20, 32);
      begin
        cpu_op(1, 4'hF, 14'h0020, 32'hA5A5A5A5, rd, lat);
        chk("starve_ovr", 32'(disp_overrun), 32'h0);
        cpu_op(0, 4'h0, 14'h0020, 32'h0, rd, lat2);
      end
    join
    chk("starve_lat1", 32'(lat), 32'd6);
    chk("starve_lat2", 32'(lat2), 32'd6);
    chk("starve_rd", rd, 32'hA5A5A5A5);
    repeat (6) @(negedge clk);
    chk("ovr_sticky", 32'(disp_overrun), 32'h1);
    chk("ovr_dropped", 32'(rv_cnt - rv0), 32'd19);
    reset_pulse();

    // simultaneous start
    fork
      disp_stream(1, 5);
      cpu_op(0, 4'h0, 14'h0003, 32'h0, rd, lat);
    join
    chk("simul_lat", 32'(lat), 32'd3);
    chk("simul_rd", rd, 32'hA0B0C003);

    // random traffic with a mid-run reset
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset_pulse();
        hold = 0;
      end
      @(negedge clk);
      disp_req  = ($urandom_range(0, 9) < 6);
      disp_addr = AW'($urandom_range(0, 63));
      if (cpu_req) begin
        if (cpu_ack) begin
          cpu_req = 1'b0;
          hold = 0;
        end else begin
          hold++;
          if (hold > 40) begin
            chk("cpu_starved", 32'(hold), 32'h0);
            cpu_req = 1'b0;
            hold = 0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_be    = BW'($urandom);
        cpu_addr  = AW'($urandom_range(0, 63));
        cpu_wdata = $urandom;
      end
    end
    @(negedge clk);
    disp_req = 1'b0;
    repeat (6) @(negedge clk);
    cpu_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
